// File: rtl/mem_pkg.sv
// Shared memory-access definitions for the
// load and store lane logic.
package mem_pkg;

  localparam logic [1:0] LS_NONE = 2'b00;
  localparam logic [1:0] LS_BYTE = 2'b01;
  localparam logic [1:0] LS_HALF = 2'b10;
  localparam logic [1:0] LS_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } ld_state_e;

  function automatic logic misaligned(
    input logic [1:0] op,
    input logic [1:0] off
  );
    return (op == LS_HALF && off[0]) ||
           (op == LS_WORD && off != 2'b00);
  endfunction

endpackage

// File: rtl/load_extract.sv
// Lane select and sign/zero extension of a
// little-endian read word.
module load_extract
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  op_i,
  input  logic        sign_i,
  output logic [31:0] val_o
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  // pick the addressed lane, then extend it
  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    b       = shifted[7:0];
    h       = off_i[1] ? rdata_i[31:16]
                       : rdata_i[15:0];
    val_o   = rdata_i;
    unique case (op_i)
      LS_BYTE: val_o = {{24{sign_i & b[7]}}, b};
      LS_HALF: val_o = {{16{sign_i & h[15]}}, h};
      default: val_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// MEM-stage load unit: req/gnt/rvalid read,
// misalign detect, timeout, extended result.
module load_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [1:0]  LSOp,
  input  logic        LdSign,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        RD_valid,
  output logic [31:0] RD_out,
  output logic        AdEL,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT_CYC - 1);

  ld_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]  off_q;
  logic [1:0]  op_q;
  logic        sign_q;
  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  logic        rd_valid_q;
  logic [31:0] rd_out_q;
  logic        adel_q;
  logic        bus_err_q;
  logic [31:0] ext_d;
  logic        tmo;

  load_extract u_ext (
    .rdata_i (mem_rdata),
    .off_i   (off_q),
    .op_i    (op_q),
    .sign_i  (sign_q),
    .val_o   (ext_d)
  );

  assign tmo = (cnt_q == CNT_LAST);

  // access FSM with registered bus and result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      off_q      <= 2'b00;
      op_q       <= LS_NONE;
      sign_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      rd_valid_q <= 1'b0;
      rd_out_q   <= '0;
      adel_q     <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      adel_q     <= 1'b0;
      bus_err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req && LSOp != LS_NONE) begin
            if (misaligned(LSOp, addr[1:0])) begin
              adel_q <= 1'b1;
            end else begin
              off_q      <= addr[1:0];
              op_q       <= LSOp;
              sign_q     <= LdSign;
              mem_addr_q <= {addr[31:2], 2'b00};
              mem_req_q  <= 1'b1;
              cnt_q      <= '0;
              state_q    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            if (mem_rvalid) begin
              rd_out_q   <= ext_d;
              rd_valid_q <= 1'b1;
              state_q    <= ST_IDLE;
            end else begin
              state_q <= ST_WAIT;
            end
          end else if (tmo) begin
            mem_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            rd_out_q   <= ext_d;
            rd_valid_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else if (tmo) begin
            bus_err_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign RD_valid = rd_valid_q;
  assign RD_out   = rd_out_q;
  assign AdEL     = adel_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit with a
// hand-sequenced memory responder.
module tb_load_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [31:0] addr;
  logic [1:0]  LSOp;
  logic        LdSign;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        RD_valid;
  logic [31:0] RD_out;
  logic        AdEL;
  logic        bus_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_unit #(.TIMEOUT_CYC(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .addr       (addr),
    .LSOp       (LSOp),
    .LdSign     (LdSign),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .RD_valid   (RD_valid),
    .RD_out     (RD_out),
    .AdEL       (AdEL),
    .bus_err    (bus_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a,
                       input logic [1:0] op,
                       input logic sg);
    req = 1'b1; addr = a; LSOp = op; LdSign = sg;
    @(negedge clk);
    req = 1'b0; addr = 32'hFFFF_FFFF;
    LSOp = 2'b11; LdSign = ~sg;
  endtask

  // gd: idle cycles before gnt; rd: cycles from
  // gnt to rvalid (0 = same cycle)
  task automatic load(input string tag,
                      input logic [31:0] a,
                      input logic [1:0] op,
                      input logic sg,
                      input int gd, input int rd,
                      input logic [31:0] data,
                      input logic [31:0] exp);
    logic [31:0] wa;
    int lat;
    wa = {a[31:2], 2'b00};
    issue(a, op, sg);
    lat = 1;
    for (int i = 0; i < gd; i++) begin
      chk({tag, ".req_hold"}, 32'(mem_req), 1);
      chk({tag, ".addr_hold"}, mem_addr, wa);
      chk({tag, ".busy_r"}, 32'(busy), 1);
      @(negedge clk); lat++;
    end
    chk({tag, ".req"}, 32'(mem_req), 1);
    chk({tag, ".addr"}, mem_addr, wa);
    mem_gnt = 1'b1;
    if (rd == 0) begin
      mem_rvalid = 1'b1; mem_rdata = data;
    end
    @(negedge clk); lat++;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'h5A5A_5A5A;
    if (rd > 0) begin
      for (int i = 1; i < rd; i++) begin
        chk({tag, ".req_off"}, 32'(mem_req), 0);
        chk({tag, ".busy_w"}, 32'(busy), 1);
        chk({tag, ".no_rv"}, 32'(RD_valid), 0);
        @(negedge clk); lat++;
      end
      chk({tag, ".busy_w"}, 32'(busy), 1);
      mem_rvalid = 1'b1; mem_rdata = data;
      @(negedge clk); lat++;
      mem_rvalid = 1'b0;
      mem_rdata = 32'h5A5A_5A5A;
    end
    chk({tag, ".valid"}, 32'(RD_valid), 1);
    chk({tag, ".data"}, RD_out, exp);
    chk({tag, ".lat"}, lat, 2 + gd + rd);
    chk({tag, ".idle"}, 32'(busy), 0);
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(RD_valid), 0);
    chk({tag, ".held"}, RD_out, exp);
  endtask

  task automatic misal(input string tag,
                       input logic [31:0] a,
                       input logic [1:0] op);
    issue(a, op, 1'b1);
    chk({tag, ".adel"}, 32'(AdEL), 1);
    chk({tag, ".noreq"}, 32'(mem_req), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".nov"}, 32'(RD_valid), 0);
    @(negedge clk);
    chk({tag, ".adel_off"}, 32'(AdEL), 0);
    chk({tag, ".noreq2"}, 32'(mem_req), 0);
  endtask

  initial begin
    logic [31:0] last;
    reset = 1'b1; req = 1'b0; addr = '0;
    LSOp = 2'b00; LdSign = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst.req", 32'(mem_req), 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.out", RD_out, 0);
    chk("rst.flags",
        {29'd0, RD_valid, AdEL, bus_err}, 0);
    reset = 1'b0;
    @(negedge clk);

    load("lb", 32'h1003, 2'b01, 1'b1, 0, 1,
         32'h80FF_1234, 32'hFFFF_FF80);
    load("lhu", 32'h2002, 2'b10, 1'b0, 0, 1,
         32'hBEEF_0001, 32'h0000_BEEF);
    load("lh", 32'h2002, 2'b10, 1'b1, 0, 1,
         32'hBEEF_0001, 32'hFFFF_BEEF);
    misal("lw_mis", 32'h3001, 2'b11);
    misal("lh_mis", 32'h3001, 2'b10);
    load("lb_odd", 32'h3001, 2'b01, 1'b1, 0, 1,
         32'h1122_A344, 32'hFFFF_FFA3);

    issue(32'h3000, 2'b00, 1'b1);
    chk("none.busy", 32'(busy), 0);
    chk("none.req", 32'(mem_req), 0);

    load("lbu_slow", 32'h5002, 2'b01, 1'b0, 4, 6,
         32'hDEAD_BEEF, 32'h0000_00AD);
    load("lh_same", 32'h5000, 2'b10, 1'b1, 2, 0,
         32'h1234_8765, 32'hFFFF_8765);

    last = RD_out;
    issue(32'h6000, 2'b11, 1'b0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("tmo.wait", 32'(bus_err), 0);
      chk("tmo.busy", 32'(busy), 1);
      @(negedge clk);
    end
    chk("tmo.err", 32'(bus_err), 1);
    chk("tmo.idle", 32'(busy), 0);
    chk("tmo.req", 32'(mem_req), 0);
    chk("tmo.nov", 32'(RD_valid), 0);
    chk("tmo.out", RD_out, last);
    @(negedge clk);
    chk("tmo.pulse", 32'(bus_err), 0);

    load("lw", 32'h4000, 2'b11, 1'b1, 0, 1,
         32'hCAFE_F00D, 32'hCAFE_F00D);

    issue(32'h7000, 2'b11, 1'b0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rstw.busy", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
    chk("rstw.idle", 32'(busy), 0);
    chk("rstw.addr", mem_addr, 0);
    chk("rstw.out", RD_out, 0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rstw.nov", 32'(RD_valid), 0);
    chk("rstw.out2", RD_out, 0);
    chk("rstw.busy2", 32'(busy), 0);
    chk("rstw.flags",
        {30'd0, mem_req, bus_err}, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
Read-side counterpart of the store byte-enable/lane-shift logic in the MEM stage. Takes a load request (address, LSOp, sign flag) and detects misalignment. Performs a request/grant/rvalid read on the word-wide data-memory bus. Extracts the addressed byte, halfword or word and sign- or zero-extends it into a registered 32-bit writeback value, stalling the pipeline via busy while the access is outstanding.

Parameters:
TIMEOUT_CYC, 255, max cycles waiting for mem_gnt/mem_rvalid before bus_err; counter width = clog2(TIMEOUT_CYC+1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req  in  1  load request from MEM stage (qualified by MemtoReg upstream); sampled only in IDLE
addr  in  32  byte address of load
LSOp  in  2  00 none, 01 byte, 10 half, 11 word (same encoding as the store path)
LdSign  in  1  1 = sign-extend (lb/lh), 0 = zero-extend (lbu/lhu); ignored for word
mem_req  out  1  read request to data memory, held until mem_gnt
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}, stable while mem_req=1
mem_gnt  in  1  memory accepted request
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word, little-endian lanes (byte0 = [7:0])
busy  out  1  1 whenever state != IDLE; pipeline stalls on it
RD_valid  out  1  one-cycle pulse, RD_out valid
RD_out  out  32  extended load result, held until next RD_valid
AdEL  out  1  one-cycle pulse: misaligned load
bus_err  out  1  one-cycle pulse: timeout

Behaviour:
- Reset: state=IDLE; mem_req=0, mem_addr=0, RD_valid=0, RD_out=0, AdEL=0, bus_err=0, busy=0, timeout counter=0. Reset mid-access aborts it; mem_rvalid arriving after reset while in IDLE is ignored.
- States: IDLE, REQ, WAIT.
- IDLE: on req=1 and LSOp!=00:
  - Misaligned if half and addr[0]=1, or word and addr[1:0]!=0. Then AdEL=1 next cycle, no bus access, stay IDLE.
  - Otherwise latch addr[1:0], LSOp, LdSign and mem_addr. Next cycle mem_req=1, state=REQ.
  - req with LSOp=00 is ignored.
- REQ: mem_req=1 until mem_gnt.
  - On mem_gnt: mem_req=0 next cycle, state=WAIT.
  - If mem_gnt and mem_rvalid are both 1 in the same cycle, complete directly and go to IDLE.
- WAIT: on mem_rvalid, go to IDLE and register the result:
  - RD_out = extracted value; RD_valid=1 for exactly one cycle.
- Extraction:
  - byte: lane addr[1:0] (0→[7:0], 1→[15:8], 2→[23:16], 3→[31:24]).
  - half: addr[1]=0→[15:0], 1→[31:16].
  - word: as-is.
  - Extension: bit 7 or 15 replicated if LdSign, else zero.
- Timeout:
  - Counter clears on entering REQ and on REQ→WAIT; it counts every cycle in REQ and in WAIT.
  - On reaching TIMEOUT_CYC without the awaited event: bus_err=1 one cycle, mem_req=0, state=IDLE, RD_out unchanged.
- Latency: request accepted at cycle 0 → mem_req at cycle 1. With zero-wait memory (gnt at cycle 1, rvalid at cycle 2), RD_valid is at cycle 3.
- req in REQ/WAIT is ignored; the upstream stage holds it under busy. A new req is accepted in the same cycle RD_valid, AdEL or bus_err is asserted, because state is IDLE then.
- AdEL, bus_err and RD_valid are mutually exclusive per access.
- busy is combinational from state; all other outputs are registered.

Decomposition:
- Shared package (mem_pkg):
  - LSOp constants LS_NONE=2'b00, LS_BYTE=2'b01, LS_HALF=2'b10, LS_WORD=2'b11, shared with the store path.
  - State encoding for IDLE/REQ/WAIT.
- Sub-module load_extract: purely combinational (rdata, addr[1:0], LSOp, LdSign → 32-bit value). Reused by any future uncached load path.

Test Plan:
- lb, addr=0x1003, LdSign=1, rdata=0x80FF_1234, zero-wait memory → mem_addr=0x1000, RD_out=0xFFFF_FF80, RD_valid at cycle 3.
- lhu, addr=0x2002, LdSign=0, rdata=0xBEEF_0001 → RD_out=0x0000_BEEF. lh at same address → 0xFFFF_BEEF.
- lw, addr=0x3001 → AdEL pulse next cycle, mem_req never asserted, busy stays 0. lh at addr=0x3001 → AdEL. lb at addr=0x3001 → normal access.
- Variable latency: gnt after 4 cycles, rvalid 6 cycles later; then a case with gnt and rvalid in the same cycle. Check mem_req/mem_addr held stable, busy=1 throughout, single RD_valid pulse, correct lane.
- TIMEOUT_CYC=8, gnt given, rvalid never → bus_err exactly 8 cycles after entering WAIT, back to IDLE. Next lw at 0x4000 completes normally.
- reset asserted in WAIT, then a stray mem_rvalid → all outputs at reset values, no RD_valid, state IDLE.
